subtrator_serial: RTL and testbench

Bit-serial unsigned/two's-complement subtractor computing `numa - numb` one bit per clock through a single full adder. It is the inverse-direction companion of the team's ripple-carry adder: it reuses the same full-adder cell, with the subtrahend inverted and the initial carry at 1. It trades latency for area, and it sits wherever a datapath has cycles to spare but not adder width. A start/done handshake frames each operation.

---
 rtl/subtrator_serial_pkg.sv | 17 +
 rtl/subtrator_serial_if.sv | 25 ++
 rtl/subtrator_serial_somadorcompleto.sv | 11 +
 rtl/subtrator_serial.sv | 87 ++++++++
 tb/tb_subtrator_serial.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/subtrator_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states, default width
// and the bit-counter width helper.
package subtrator_serial_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CALC   = 2'd1,
    FIM    = 2'd2
  } estado_t;

  localparam int WIDTH_PADRAO = 4;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/subtrator_serial_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
interface subtrator_serial_if
  import subtrator_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_PADRAO
);
  logic             inicio;
  logic [WIDTH-1:0] numa;
  logic [WIDTH-1:0] numb;
  logic [WIDTH-1:0] diferenca;
  logic             emprestimo;
  logic             overflow;
  logic             ocupado;
  logic             pronto;

  modport master (
    output inicio, numa, numb,
    input  diferenca, emprestimo, overflow, ocupado, pronto
  );

  modport slave (
    input  inicio, numa, numb,
    output diferenca, emprestimo, overflow, ocupado, pronto
  );
endinterface

// File: rtl/subtrator_serial_somadorcompleto.sv
// One-bit full adder cell, shared with the ripple-carry adder.
module somadorcompleto (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial subtractor: numa - numb, LSB first, one full-adder evaluation per
// clock, using numa + ~numb + 1.
module subtrator_serial
  import subtrator_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_PADRAO
) (
  input logic              clk,
  input logic              rst,
  subtrator_serial_if.slave bus
);
  localparam int            CW     = cnt_w(WIDTH);
  localparam logic [CW-1:0] ULTIMO = CW'(WIDTH - 1);

  estado_t          r_estado, w_prox;
  logic [WIDTH-1:0] r_a, r_b, r_parcial, r_dif;
  logic             r_carry, r_emp, r_ovf;
  logic [CW-1:0]    r_cnt;
  logic             w_soma, w_co, w_ultimo;

  somadorcompleto u_fa (
    .i_a  (r_a[0]),
    .i_b  (~r_b[0]),
    .i_ci (r_carry),
    .o_s  (w_soma),
    .o_co (w_co)
  );

  assign w_ultimo = (r_cnt == ULTIMO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_estado <= OCIOSO;
    else     r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO:  if (bus.inicio) w_prox = CALC;
      CALC:    if (w_ultimo)   w_prox = FIM;
      FIM:     w_prox = OCIOSO;
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_parcial <= '0;
      r_dif     <= '0;
      r_carry   <= 1'b0;
      r_emp     <= 1'b0;
      r_ovf     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_estado)
        OCIOSO: if (bus.inicio) begin
          r_a     <= bus.numa;
          r_b     <= bus.numb;
          r_carry <= 1'b1;
          r_cnt   <= '0;
        end
        CALC: begin
          r_parcial <= {w_soma, r_parcial[WIDTH-1:1]};
          r_a       <= r_a >> 1;
          r_b       <= r_b >> 1;
          r_carry   <= w_co;
          r_cnt     <= r_cnt + 1'b1;
          // r_carry here is the carry into the MSB slice
          if (w_ultimo) begin
            r_dif <= {w_soma, r_parcial[WIDTH-1:1]};
            r_emp <= ~w_co;
            r_ovf <= r_carry ^ w_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.diferenca  = r_dif;
  assign bus.emprestimo = r_emp;
  assign bus.overflow   = r_ovf;
  assign bus.ocupado    = (r_estado != OCIOSO);
  assign bus.pronto     = (r_estado == FIM);
endmodule

// File: tb/tb_subtrator_serial.sv
// Scoreboard bench for subtrator_serial at WIDTH=4 and WIDTH=8.
module tb_subtrator_serial;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  subtrator_serial_if #(.WIDTH(4)) if4 ();
  subtrator_serial_if #(.WIDTH(8)) if8 ();

  subtrator_serial #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  subtrator_serial #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  typedef struct {
    int dif;
    bit emp;
    bit ovf;
    int acc;
  } esp_t;

  esp_t q4[$];
  esp_t q8[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   hdif4 = 0, hdif8 = 0;
  bit   hemp4 = 0, hovf4 = 0, hemp8 = 0, hovf8 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic esp_t modelo(int w, int a, int b, int acc);
    esp_t e;
    int   sa, sb, d;
    e.dif = (a - b) & ((1 << w) - 1);
    e.emp = (a < b);
    sa    = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb    = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    d     = sa - sb;
    e.ovf = (d > (1 << (w - 1)) - 1) || (d < -(1 << (w - 1)));
    e.acc = acc;
    return e;
  endfunction

  task automatic chk(string nome, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nome, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : mon4
    esp_t e;
    bit   busy_exp;
    bit   last_pronto;
    busy_exp = (q4.size() > 0) && (cyc >= q4[0].acc);
    chk("w4 ocupado", int'(if4.ocupado), int'(busy_exp));
    if (if4.pronto) begin
      chk("w4 pronto width", int'(last_pronto), 0);
      if (q4.size() == 0) chk("w4 spurious pronto", 1, 0);
      else begin
        e = q4.pop_front();
        chk("w4 latency", cyc - e.acc, 4);
        hdif4 = e.dif; hemp4 = e.emp; hovf4 = e.ovf;
      end
    end
    chk("w4 diferenca",  int'(if4.diferenca),  hdif4);
    chk("w4 emprestimo", int'(if4.emprestimo), int'(hemp4));
    chk("w4 overflow",   int'(if4.overflow),   int'(hovf4));
    last_pronto = if4.pronto;
  end

  always @(negedge clk) begin : mon8
    esp_t e;
    bit   busy_exp;
    bit   last_pronto;
    busy_exp = (q8.size() > 0) && (cyc >= q8[0].acc);
    chk("w8 ocupado", int'(if8.ocupado), int'(busy_exp));
    if (if8.pronto) begin
      chk("w8 pronto width", int'(last_pronto), 0);
      if (q8.size() == 0) chk("w8 spurious pronto", 1, 0);
      else begin
        e = q8.pop_front();
        chk("w8 latency", cyc - e.acc, 8);
        hdif8 = e.dif; hemp8 = e.emp; hovf8 = e.ovf;
      end
    end
    chk("w8 diferenca",  int'(if8.diferenca),  hdif8);
    chk("w8 emprestimo", int'(if8.emprestimo), int'(hemp8));
    chk("w8 overflow",   int'(if8.overflow),   int'(hovf8));
    last_pronto = if8.pronto;
  end

  // Wait for idle, present one request for exactly one accepting edge.
  task automatic op4(int a, int b);
    @(negedge clk);
    for (int k = 0; k < 50 && if4.ocupado; k++) @(negedge clk);
    if (if4.ocupado) begin
      chk("w4 idle timeout", 1, 0);
      return;
    end
    if4.numa = 4'(a); if4.numb = 4'(b); if4.inicio = 1'b1;
    q4.push_back(modelo(4, a, b, cyc + 1));
    @(negedge clk);
    if4.inicio = 1'b0;
  endtask

  task automatic op8(int a, int b);
    @(negedge clk);
    for (int k = 0; k < 50 && if8.ocupado; k++) @(negedge clk);
    if (if8.ocupado) begin
      chk("w8 idle timeout", 1, 0);
      return;
    end
    if8.numa = 8'(a); if8.numb = 8'(b); if8.inicio = 1'b1;
    q8.push_back(modelo(8, a, b, cyc + 1));
    @(negedge clk);
    if8.inicio = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    q4.delete(); q8.delete();
    hdif4 = 0; hemp4 = 0; hovf4 = 0;
    hdif8 = 0; hemp8 = 0; hovf8 = 0;
  endtask

  initial begin
    int a, b;
    if4.inicio = 1'b0; if4.numa = '0; if4.numb = '0;
    if8.inicio = 1'b0; if8.numa = '0; if8.numb = '0;
    #1 reset_pulse();
    repeat (2) @(negedge clk);
    chk("reset diferenca", int'(if4.diferenca), 0);
    chk("reset flags", int'({if4.emprestimo, if4.overflow, if4.ocupado, if4.pronto}), 0);
    rst = 1'b0;

    op4(7, 3);
    op4(3, 7);
    op4(0, 0);
    op4(8, 1);
    op4(7, 15);

    // Request during CALC must be ignored.
    op4(6, 2);
    @(negedge clk);
    if4.numa = 4'd15; if4.numb = 4'd0; if4.inicio = 1'b1;
    @(negedge clk);
    if4.inicio = 1'b0;

    // Held start: accepts every WIDTH+2 edges.
    op4(1, 1);
    for (int k = 0; k < 50 && if4.ocupado; k++) @(negedge clk);
    if4.inicio = 1'b1;
    for (int n = 0; n < 5; n++) begin
      a = $urandom_range(0, 15); b = $urandom_range(0, 15);
      if4.numa = 4'(a); if4.numb = 4'(b);
      q4.push_back(modelo(4, a, b, cyc + 1));
      repeat (6) @(negedge clk);
    end
    if4.inicio = 1'b0;

    // Asynchronous reset between E2 and E3 aborts silently.
    op4(5, 3);
    @(posedge clk);
    @(posedge clk);
    #2 reset_pulse();
    #1;
    chk("abort diferenca", int'(if4.diferenca), 0);
    chk("abort flags", int'({if4.emprestimo, if4.overflow, if4.ocupado, if4.pronto}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    op4(9, 5);

    for (int n = 0; n < 20; n++) begin
      op4($urandom_range(0, 15), $urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    op8(8'h00, 8'h01);
    op8(8'h80, 8'h01);
    op8(8'h7F, 8'hFF);
    for (int n = 0; n < 8; n++) op8($urandom_range(0, 255), $urandom_range(0, 255));

    for (int k = 0; k < 100 && (q4.size() > 0 || q8.size() > 0); k++) @(negedge clk);
    chk("drain w4", q4.size(), 0);
    chk("drain w8", q8.size(), 0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
